dla_reset_sequencer: RTL and testbench

Initiator side of the reset handshake: generates a reset for NUM_DOMAINS downstream clock domains and confirms that each domain has entered and then left reset. Every downstream domain converts this block's reset output to a synchronous reset with its local reset synchronizer. That synchronizer's output comes back to this block as an acknowledge, which this block resynchronizes into its own clock domain. The block sits in the top-level reset/control logic and runs a sequence on local reset and on each soft-reset request.

---
 rtl/dla_reset_sequencer_pkg.sv | 18 +
 rtl/dla_clock_cross_half_sync.sv | 20 ++
 rtl/dla_reset_sequencer.sv | 117 +++++++++++
 tb/tb_dla_reset_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dla_reset_sequencer_pkg.sv
// Shared types and sizing helpers for the downstream reset handshake sequencer.
package dla_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    WAIT_IN  = 2'd2,
    WAIT_OUT = 2'd3
  } seq_state_e;

  // One counter serves both the assert hold and the wait timeouts.
  function automatic int cnt_width(input int min_assert, input int timeout);
    int m;
    m = (min_assert > timeout) ? min_assert : timeout;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/dla_clock_cross_half_sync.sv
// Multi-flop synchronizer bringing one asynchronous bit into the destination clock domain.
module dla_clock_cross_half_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic i_dst_async_resetn,
  input  logic i_async_data,
  output logic o_sync_data
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge i_dst_async_resetn) begin
    if (!i_dst_async_resetn) sync_q <= '0;
    else                     sync_q <= {sync_q[STAGES-2:0], i_async_data};
  end

  assign o_sync_data = sync_q[STAGES-1];

endmodule

// File: rtl/dla_reset_sequencer.sv
// Drives the downstream reset and checks that every domain enters and leaves reset.
module dla_reset_sequencer
  import dla_reset_sequencer_pkg::*;
#(
  parameter int NUM_DOMAINS       = 1,
  parameter int MIN_ASSERT_CYCLES = 16,
  parameter int TIMEOUT_CYCLES    = 4096
) (
  input  logic                   clk,
  input  logic                   i_sreset,
  input  logic                   i_reset_req,
  output logic                   o_async_resetn,
  input  logic [NUM_DOMAINS-1:0] i_async_ack_resetn,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_timeout
);

  localparam int CW = cnt_width(MIN_ASSERT_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CW-1:0] MIN_C   = CW'(MIN_ASSERT_CYCLES);
  localparam logic [CW-1:0] TO_C    = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = '1;

  if (NUM_DOMAINS < 1)       begin : g_bad_nd  $error("NUM_DOMAINS must be >= 1");       end
  if (MIN_ASSERT_CYCLES < 1) begin : g_bad_min $error("MIN_ASSERT_CYCLES must be >= 1"); end

  logic [NUM_DOMAINS-1:0] ack_sync;

  for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_ack_sync
    dla_clock_cross_half_sync u_sync (
      .clk                (clk),
      .i_dst_async_resetn (1'b1),
      .i_async_data       (i_async_ack_resetn[d]),
      .o_sync_data        (ack_sync[d])
    );
  end

  seq_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          pend_q, resetn_q, busy_q, done_q, timeout_q;
  logic          ack_lo, ack_hi, to_hit;

  always_comb begin
    cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    ack_lo = ~|ack_sync;
    ack_hi = &ack_sync;
    to_hit = (TIMEOUT_CYCLES != 0) && (cnt_d == TO_C);
  end

  always_ff @(posedge clk) begin
    if (i_sreset) begin
      state_q   <= ASSERT;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      resetn_q  <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Requests while busy fold into one extra sequence.
      if (i_reset_req && state_q != IDLE) pend_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (i_reset_req || pend_q) begin
            state_q   <= ASSERT;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            timeout_q <= 1'b0;
            resetn_q  <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        ASSERT: begin
          if (cnt_d == MIN_C) begin
            state_q <= WAIT_IN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        WAIT_IN: begin
          if (ack_lo || to_hit) begin
            state_q  <= WAIT_OUT;
            cnt_q    <= '0;
            resetn_q <= 1'b1;
            if (!ack_lo) timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        WAIT_OUT: begin
          if (ack_hi || to_hit) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (!ack_hi) timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= ASSERT;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign o_async_resetn = resetn_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_dla_reset_sequencer.sv
// Scoreboard bench: each sequence's expected low-time and timeout flag are checked at o_done.
module tb_dla_reset_sequencer;

  localparam int ND = 2;

  logic          clk = 1'b0;
  logic          sreset = 1'b1;
  logic          req = 1'b0;
  logic          resetn, busy, done, tmo;
  logic [ND-1:0] ack;
  logic [ND-1:0] stick = '0;
  logic [ND-1:0][2:0] dly = '1;

  typedef struct { int lowlen; bit to; } exp_t;
  exp_t expq[$];

  int vecs = 0;
  int miss = 0;
  int lowlen = 0;

  always #5 clk = ~clk;

  dla_reset_sequencer #(
    .NUM_DOMAINS(ND), .MIN_ASSERT_CYCLES(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk                (clk),
    .i_sreset           (sreset),
    .i_reset_req        (req),
    .o_async_resetn     (resetn),
    .i_async_ack_resetn (ack),
    .o_busy             (busy),
    .o_done             (done),
    .o_timeout          (tmo)
  );

  // Each downstream domain answers three cycles after the reset it sees.
  always @(posedge clk)
    for (int d = 0; d < ND; d++) dly[d] <= {dly[d][1:0], resetn};
  always_comb
    for (int d = 0; d < ND; d++) ack[d] = stick[d] | dly[d][2];

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sreset) lowlen = 0;
    else if (resetn === 1'b0) lowlen++;
    if (done === 1'b1) begin
      if (expq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("seq_low_cycles", lowlen, e.lowlen);
        chk("seq_timeout", int'(tmo), int'(e.to));
        chk("busy_at_done", int'(busy), 0);
      end
      lowlen = 0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_req();
    req = 1'b1; tick(); req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() > 0 && n < 400) begin tick(); n++; end
    if (expq.size() > 0) begin
      chk("drain_timeout", expq.size(), 0);
      expq.delete();
    end
    tick(3);
  endtask

  initial begin
    // Reset state and first sequence after release.
    tick(2);
    chk("rst_resetn", int'(resetn), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_timeout", int'(tmo), 0);
    tick(8);
    expq.push_back('{5, 1'b0});
    sreset = 1'b0;
    drain();

    // Request from IDLE: reset low on the next cycle.
    expq.push_back('{6, 1'b0});
    pulse_req();
    chk("req_resetn_t1", int'(resetn), 0);
    chk("req_busy_t1", int'(busy), 1);
    drain();

    // Domain 1 never enters reset: WAIT_IN times out.
    stick[1] = 1'b1;
    expq.push_back('{12, 1'b1});
    pulse_req();
    drain();
    tick(5);
    chk("timeout_sticky", int'(tmo), 1);
    stick[1] = 1'b0;
    expq.push_back('{6, 1'b0});
    pulse_req();
    chk("timeout_cleared", int'(tmo), 0);
    drain();

    // Three requests while busy yield one extra sequence.
    expq.push_back('{6, 1'b0});
    expq.push_back('{6, 1'b0});
    pulse_req();
    tick(2); pulse_req();
    tick(2); pulse_req();
    tick(3); pulse_req();
    drain();
    tick(20);
    chk("pending_idle_busy", int'(busy), 0);

    // Reset in WAIT_OUT with timeout set.
    stick[1] = 1'b1;
    pulse_req();
    tick(14);
    chk("pre_rst_timeout", int'(tmo), 1);
    sreset = 1'b1;
    tick();
    chk("mid_rst_resetn", int'(resetn), 0);
    chk("mid_rst_busy", int'(busy), 1);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_timeout", int'(tmo), 0);
    stick[1] = 1'b0;
    tick(9);
    expq.push_back('{5, 1'b0});
    sreset = 1'b0;
    drain();

    // Request coincident with reset is swallowed by reset.
    sreset = 1'b1; req = 1'b1;
    tick();
    req = 1'b0;
    chk("both_resetn", int'(resetn), 0);
    chk("both_busy", int'(busy), 1);
    tick(9);
    expq.push_back('{5, 1'b0});
    sreset = 1'b0;
    drain();
    tick(5);
    chk("both_no_pending", int'(busy), 0);
    tick(20);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
